// File: rtl/cla_add32_pipe_pkg.sv
// cla_add32_pipe_pkg: shared widths and the stage-1 register layout
package cla_add32_pipe_pkg;
    localparam int WIDTH = 32;
    localparam int SECT  = 16;
    localparam int GRP   = 4;

    typedef struct packed {
        logic [SECT-1:0] sum_lo;
        logic            c16;
        logic            g_lo;
        logic            p_lo;
        logic [SECT-1:0] a_hi;
        logic [SECT-1:0] b_hi;
    } s1_t;
endpackage

// File: rtl/cla_add32_pipe_add16.sv
// cla_add16: combinational 16-bit lookahead section built from four 4-bit groups
module cla_add16
    import cla_add32_pipe_pkg::*;
(
    input  logic [SECT-1:0] x,
    input  logic [SECT-1:0] y,
    input  logic            c0,
    output logic [SECT-1:0] s,
    output logic            c16,
    output logic            gx,
    output logic            px
);
    localparam int NG = SECT / GRP;

    logic [SECT-1:0] w_g, w_p, w_c;
    logic [NG-1:0]   w_gg, w_gp, w_gc;

    assign w_g = x & y;
    assign w_p = x ^ y;

    genvar k;
    for (k = 0; k < NG; k++) begin : g_grp
        localparam int L = k * GRP;
        assign w_gg[k]  = w_g[L+3] | (w_p[L+3] & w_g[L+2]) | (&w_p[L+3:L+2] & w_g[L+1])
                        | (&w_p[L+3:L+1] & w_g[L]);
        assign w_gp[k]  = &w_p[L+3:L];
        assign w_c[L]   = w_gc[k];
        assign w_c[L+1] = w_g[L] | (w_p[L] & w_gc[k]);
        assign w_c[L+2] = w_g[L+1] | (w_p[L+1] & w_g[L]) | (&w_p[L+1:L] & w_gc[k]);
        assign w_c[L+3] = w_g[L+2] | (w_p[L+2] & w_g[L+1]) | (&w_p[L+2:L+1] & w_g[L])
                        | (&w_p[L+2:L] & w_gc[k]);
    end

    // group carries come straight from the section-level lookahead, never from a neighbour group
    assign w_gc[0] = c0;
    assign w_gc[1] = w_gg[0] | (w_gp[0] & c0);
    assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (&w_gp[1:0] & c0);
    assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (&w_gp[2:1] & w_gg[0]) | (&w_gp[2:0] & c0);

    assign gx  = w_gg[3] | (w_gp[3] & w_gg[2]) | (&w_gp[3:2] & w_gg[1]) | (&w_gp[3:1] & w_gg[0]);
    assign px  = &w_gp;
    assign c16 = gx | (px & c0);
    assign s   = w_p ^ w_c;
endmodule

// File: rtl/cla_add32_pipe.sv
// cla_add32_pipe: two-stage pipelined 32-bit lookahead adder with valid/ready handshake
module cla_add32_pipe
    import cla_add32_pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             gx,
    output logic             px,
    output logic             out_valid,
    input  logic             out_ready
);
    s1_t             r_s1, w_s1;
    logic            r_v1, r_v2;
    logic [WIDTH-1:0] r_sum;
    logic            r_cout, r_ovf, r_gx, r_px;
    logic            w_ld1, w_ld2;
    logic [SECT-1:0] w_s_lo, w_s_hi;
    logic            w_c16, w_g_lo, w_p_lo, w_c32, w_g_hi, w_p_hi, w_ovf;

    cla_add16 u_lo (
        .x   (a[SECT-1:0]),
        .y   (b[SECT-1:0]),
        .c0  (cin),
        .s   (w_s_lo),
        .c16 (w_c16),
        .gx  (w_g_lo),
        .px  (w_p_lo)
    );

    cla_add16 u_hi (
        .x   (r_s1.a_hi),
        .y   (r_s1.b_hi),
        .c0  (r_s1.c16),
        .s   (w_s_hi),
        .c16 (w_c32),
        .gx  (w_g_hi),
        .px  (w_p_hi)
    );

    assign w_s1 = '{sum_lo: w_s_lo, c16: w_c16, g_lo: w_g_lo, p_lo: w_p_lo,
                    a_hi: a[WIDTH-1:SECT], b_hi: b[WIDTH-1:SECT]};
    assign w_ovf = (r_s1.a_hi[SECT-1] == r_s1.b_hi[SECT-1]) & (w_s_hi[SECT-1] != r_s1.a_hi[SECT-1]);

    // stage 1 can always take a new operand unless both stages are full and the output is stalled
    assign in_ready = !r_v1 | !r_v2 | out_ready;
    assign w_ld1    = in_valid & in_ready;
    assign w_ld2    = r_v1 & (!r_v2 | out_ready);

    // valid bits: a load sets, a hand-off or consume without refill clears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
        end else begin
            r_v1 <= w_ld1 | (r_v1 & !w_ld2);
            r_v2 <= w_ld2 | (r_v2 & !out_ready);
        end
    end

    // stage-1 data: low-half result plus the high operand halves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_s1 <= '0;
        else if (w_ld1) r_s1 <= w_s1;
    end

    // stage-2 data: full result and the two-level group lookahead terms
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_gx   <= 1'b0;
            r_px   <= 1'b0;
        end else if (w_ld2) begin
            r_sum  <= {w_s_hi, r_s1.sum_lo};
            r_cout <= w_c32;
            r_ovf  <= w_ovf;
            r_gx   <= w_g_hi | (w_p_hi & r_s1.g_lo);
            r_px   <= w_p_hi & r_s1.p_lo;
        end
    end

    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign gx        = r_gx;
    assign px        = r_px;
    assign out_valid = r_v2;
endmodule

// File: tb/tb_cla_add32_pipe.sv
// tb_cla_add32_pipe: directed and streamed checks of the pipelined lookahead adder
module tb_cla_add32_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        cin = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, cout, ovf, gx, px, out_valid;
    logic [31:0] sum;
    int          n_chk = 0, n_err = 0;
    logic [31:0] op_a [0:127];
    logic [31:0] op_b [0:127];
    logic        op_c [0:127];

    cla_add32_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .gx        (gx),
        .px        (px),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run1(input string tag, input logic [31:0] xa, input logic [31:0] xb, input logic xc,
                        input logic [31:0] es, input logic ec, input logic eo, input logic eg, input logic ep);
        @(negedge clk);
        a = xa; b = xb; cin = xc; in_valid = 1'b1; out_ready = 1'b1;
        #1 chk({tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        #1 chk({tag, "_early"}, out_valid, 0);
        @(negedge clk);
        #1;
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_ovf"}, ovf, eo);
        chk({tag, "_gx"}, gx, eg);
        chk({tag, "_px"}, px, ep);
        @(negedge clk);
        #1 chk({tag, "_one_cycle"}, out_valid, 0);
    endtask

    task automatic stream(input string tag, input int n, input int stall);
        int sent = 0, got = 0, cyc = 0, bubbles = 0;
        logic [32:0] e, e0;
        e0 = {1'b0, op_a[0]} + {1'b0, op_b[0]} + {32'b0, op_c[0]};
        while (got < n && cyc < n + stall + 20) begin
            @(negedge clk);
            out_ready = (cyc >= stall);
            in_valid  = (sent < n);
            if (sent < n) begin
                a = op_a[sent]; b = op_b[sent]; cin = op_c[sent];
            end
            #1;
            if (stall > 0 && cyc == stall - 1) begin
                chk({tag, "_bp_in_ready"}, in_ready, 0);
                chk({tag, "_bp_accepts"}, sent, 2);
                chk({tag, "_bp_hold_valid"}, out_valid, 1);
                chk({tag, "_bp_hold_sum"}, sum, e0[31:0]);
            end
            if (got > 0 && !out_valid) bubbles++;
            if (out_valid && out_ready) begin
                e = {1'b0, op_a[got]} + {1'b0, op_b[got]} + {32'b0, op_c[got]};
                chk({tag, "_sum"}, sum, e[31:0]);
                chk({tag, "_cout"}, cout, e[32]);
                chk({tag, "_ovf"}, ovf, (op_a[got][31] == op_b[got][31]) && (e[31] != op_a[got][31]));
                got++;
            end
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, "_count"}, got, n);
        chk({tag, "_bubbles"}, bubbles, 0);
    endtask

    initial begin
        int ghosts;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_flags", {cout, ovf, gx, px}, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        run1("basic", 32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 0, 0, 0, 0);
        run1("chain", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1, 0, 0, 1);
        run1("wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1, 0, 1, 0);
        run1("ovfp",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 0, 1, 0, 0);
        run1("ovfn",  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1, 1, 1, 0);

        op_a[0] = 32'h0000_0010; op_b[0] = 32'h0000_0020; op_c[0] = 1'b0;
        op_a[1] = 32'hFFFF_0000; op_b[1] = 32'h0001_0000; op_c[1] = 1'b0;
        op_a[2] = 32'h1234_5678; op_b[2] = 32'h8765_4321; op_c[2] = 1'b1;
        op_a[3] = 32'h8000_0001; op_b[3] = 32'h7FFF_FFFF; op_c[3] = 1'b1;
        stream("bp", 4, 6);

        for (int i = 0; i < 100; i++) begin
            op_a[i] = $urandom; op_b[i] = $urandom; op_c[i] = 1'($urandom_range(0, 1));
        end
        stream("b2b", 100, 0);

        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; a = 32'h0000_0005; b = 32'h0000_0006; cin = 1'b0;
        @(negedge clk);
        a = 32'h0000_0007;
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("mid_full", {out_valid, in_ready}, 2'b10);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_sum", sum, 0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        ghosts = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1 if (out_valid) ghosts++;
        end
        chk("mid_rst_ghosts", ghosts, 0);
        run1("post", 32'h0000_00FF, 32'h0000_0001, 1'b1, 32'h0000_0101, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/cla_add32_pipe.md
CLA_ADD32_PIPE -- requirements
Module: cla_add32_pipe

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  input  1  sole clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- a  input  32  augend
- b  input  32  addend
- cin  input  1  carry-in
- in_valid  input  1  operands valid
- in_ready  output  1  block accepts operands this cycle
- sum  output  32  a + b + cin, modulo 2^32
- cout  output  1  carry out of bit 31
- ovf  output  1  signed overflow
- gx  output  1  32-bit group generate, for external lookahead
- px  output  1  32-bit group propagate, for external lookahead
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result

REQ-002 The reset SHALL be asynchronous and active-low.

REQ-003 The block SHALL use one clock only.

Function
REQ-004 The adder SHALL be a carry-lookahead adder with 4-bit groups and 16-bit sections, with no ripple carry between 4-bit groups.

REQ-005 Stage 1 SHALL compute the bits [15:0] sum, carry c16, and section G/P for the low half. It SHALL register these together with a[31:16], b[31:16] and a valid bit v1.

REQ-006 Stage 2 SHALL compute bits [31:16] using the registered c16. It SHALL register sum, cout, ovf, gx, px and a valid bit v2.

REQ-007 Outputs SHALL be driven directly from the stage-2 registers; out_valid = v2.

REQ-008 Latency SHALL be exactly 2 cycles from the accepting edge (in_valid & in_ready) to out_valid when there is no backpressure. Throughput SHALL be 1 result per cycle.

REQ-009 The block SHALL assert ovf = (a[31] == b[31]) & (sum[31] != a[31]). cout SHALL equal the carry out of bit 31.

REQ-010 gx/px SHALL be the two-level lookahead combination: gx = G_hi | (P_hi & G_lo) and px = P_hi & P_lo. Neither SHALL depend on cin.

REQ-011 Stage 2 SHALL load when v1 & (!v2 | out_ready). Stage 1 SHALL load when in_valid & in_ready.

REQ-012 in_ready SHALL equal !v1 | !v2 | out_ready, as combinational logic that does not depend on in_valid.

REQ-013 v1 SHALL clear when stage 1 hands off to stage 2 and no new operand is accepted that cycle. v2 SHALL clear when out_valid & out_ready occur and stage 1 does not hand off that cycle.

REQ-014 Under out_ready = 0, out_valid and all result outputs SHALL hold stable until the result is accepted. The pipeline SHALL hold at most 2 results; none SHALL be lost or duplicated.

REQ-015 A simultaneous accept at the input, hand-off, and output consume SHALL all take effect in the same cycle, so a full pipeline streams without a bubble.

REQ-016 Overflow of the 32-bit sum SHALL wrap modulo 2^32; cout reports the carry.

REQ-017 Data registers MAY load unconditionally when their valid bit is 0. Outputs are meaningful only while out_valid = 1.

Reset
REQ-018 While rst_n = 0, v1 and v2 SHALL be 0 and all data registers SHALL be 0. Consequently out_valid = 0, sum = 0, cout = 0, ovf = 0, gx = 0, px = 0 and in_ready = 1.

REQ-019 Reset asserted mid-operation SHALL discard all in-flight results immediately and asynchronously.

REQ-020 After reset deasserts, the first accept SHALL be possible on the first rising clock edge.

Structure
REQ-021 A shared package SHALL hold WIDTH = 32, SECT = 16 and GRP = 4, plus a struct for the stage-1 register contents.

REQ-022 One sub-module, cla_add16, SHALL be instantiated twice. It is combinational, with inputs x[15:0], y[15:0], c0 and outputs s[15:0], c16, gx, px, built from four 4-bit lookahead groups.

REQ-023 The pipeline registers and handshake logic SHALL reside only in cla_add32_pipe.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- Basic add: a = 0x0000_0001, b = 0x0000_0002, cin = 0, out_ready = 1 -> 2 cycles later sum = 0x0000_0003, cout = 0, ovf = 0, out_valid = 1 for 1 cycle.
- Full carry chain: a = 0xFFFF_FFFF, b = 0, cin = 1 -> sum = 0, cout = 1, ovf = 0, gx = 0, px = 1.
- Signed overflow: a = 0x7FFF_FFFF, b = 1, cin = 0 -> sum = 0x8000_0000, ovf = 1, cout = 0. Also a = b = 0x8000_0000 -> sum = 0, cout = 1, ovf = 1.
- Backpressure: stream 4 operands with out_ready = 0 -> in_ready drops after 2 accepts and outputs hold. Then out_ready = 1 -> results arrive in order, no bubble, no loss.
- Back-to-back streaming: 100 random operand pairs, in_valid and out_ready both held at 1 -> one result per cycle, each matching a reference model (a + b + cin).
- Reset mid-stream: assert rst_n = 0 with v1 = v2 = 1 -> out_valid = 0 immediately and in_ready = 1. The results in flight at reset never appear after release.
